// File: rtl/arb_pkg.sv
// Shared definitions for the data-memory arbiter: lock FSM state encoding,
// requester indices and default fairness/burst limits.
package arb_pkg;

   typedef enum logic {
      S_CPU  = 1'b0,
      S_LOCK = 1'b1
   } arb_state_t;

   localparam int REQ_CPU = 0;
   localparam int REQ_DMA = 1;

   localparam int STREAK_MAX_DEF = 4;
   localparam int BURST_MAX_DEF  = 8;

endpackage

// File: rtl/arb_lock_fsm.sv
// Grant qualifier logic for the data-memory arbiter. Holds the lock state,
// the beat count of a locked DMA burst and the CPU streak counter that
// forces a DMA slot when the DMA has been waiting too long.
module arb_lock_fsm
   import arb_pkg::*;
#(
   parameter int STREAK_MAX = STREAK_MAX_DEF,
   parameter int BURST_MAX  = BURST_MAX_DEF
) (
   input  logic clk,
   input  logic rst,
   input  logic cpu_req,
   input  logic dma_req,
   input  logic dma_lock,
   output logic dma_gnt,
   output logic gnt_cpu
);

   localparam bit CAN_LOCK = (BURST_MAX > 1);

   arb_state_t state;
   arb_state_t state_next;
   logic [3:0] streak;
   logic [3:0] streak_next;
   logic [7:0] beats;
   logic [7:0] beats_next;
   logic       streak_full;
   logic       burst_last;

   assign streak_full = (streak == 4'(STREAK_MAX));
   assign burst_last  = (({1'b0, beats} + 9'd1) == 9'(BURST_MAX));

   // Grant decision: CPU wins by default, DMA wins when the CPU is idle, when the CPU streak is exhausted, or always while locked
   always_comb begin
      dma_gnt = 1'b0;
      gnt_cpu = 1'b0;
      if (rst) begin
         case (state)
            S_CPU: begin
               dma_gnt = dma_req && (!cpu_req || streak_full);
               gnt_cpu = cpu_req && !dma_gnt;
            end
            S_LOCK: begin
               dma_gnt = dma_req;
               gnt_cpu = 1'b0;
            end
            default: begin
               dma_gnt = 1'b0;
               gnt_cpu = 1'b0;
            end
         endcase
      end
   end

   // Next lock state and beat count; a dropped request or the final allowed beat ends the burst
   always_comb begin
      state_next = state;
      beats_next = beats;
      case (state)
         S_CPU: begin
            if (dma_gnt && dma_lock && CAN_LOCK) begin
               state_next = S_LOCK;
               beats_next = 8'd1;
            end
         end
         S_LOCK: begin
            if (!dma_req || !dma_lock || burst_last) begin
               state_next = S_CPU;
               beats_next = 8'd0;
            end else begin
               beats_next = beats + 8'd1;
            end
         end
         default: begin
            state_next = S_CPU;
            beats_next = 8'd0;
         end
      endcase
   end

   // Streak counts CPU grants taken while the DMA waits; any DMA grant or idle DMA clears it
   always_comb begin
      streak_next = streak;
      if (dma_gnt || !dma_req) begin
         streak_next = 4'd0;
      end else if (gnt_cpu && !streak_full) begin
         streak_next = streak + 4'd1;
      end
   end

   // State register; reset abandons any burst in progress
   always_ff @(posedge clk) begin
      if (!rst) begin
         state  <= S_CPU;
         streak <= 4'd0;
         beats  <= 8'd0;
      end else begin
         state  <= state_next;
         streak <= streak_next;
         beats  <= beats_next;
      end
   end

endmodule

// File: rtl/dmem_arbiter.sv
// Data-memory port arbiter between the CPU MEM stage and a DMA/loader master.
// Optional performance counters are built when ARB_PERF_CNT_EN is defined;
// otherwise the perf ports read 0 and no counter flops exist.
module dmem_arbiter
   import arb_pkg::*;
#(
   parameter int ADDR_W     = 32,
   parameter int DATA_W     = 32,
   parameter int STREAK_MAX = STREAK_MAX_DEF,
   parameter int BURST_MAX  = BURST_MAX_DEF
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              cpu_rd,
   input  logic              cpu_wr,
   input  logic [ADDR_W-1:0] cpu_addr,
   input  logic [DATA_W-1:0] cpu_wdata,
   output logic [DATA_W-1:0] cpu_rdata,
   output logic              cpu_stall,
   input  logic              dma_req,
   input  logic              dma_we,
   input  logic              dma_lock,
   input  logic [ADDR_W-1:0] dma_addr,
   input  logic [DATA_W-1:0] dma_wdata,
   output logic              dma_gnt,
   output logic [DATA_W-1:0] dma_rdata,
   output logic              dma_rvalid,
   output logic              mem_rd,
   output logic              mem_wr,
   output logic [ADDR_W-1:0] mem_addr,
   output logic [DATA_W-1:0] mem_wdata,
   input  logic [DATA_W-1:0] mem_rdata,
   output logic [31:0]       perf_stall_cnt,
   output logic [31:0]       perf_dma_cnt
);

   logic       cpu_req;
   logic       cpu_read;
   logic       gnt_cpu;
   logic       dma_read_gnt;
   logic [1:0] owner;

   assign cpu_req  = cpu_rd | cpu_wr;
   assign cpu_read = cpu_rd && !cpu_wr;

   arb_lock_fsm #(
      .STREAK_MAX(STREAK_MAX),
      .BURST_MAX (BURST_MAX)
   ) u_lock_fsm (
      .clk     (clk),
      .rst     (rst),
      .cpu_req (cpu_req),
      .dma_req (dma_req),
      .dma_lock(dma_lock),
      .dma_gnt (dma_gnt),
      .gnt_cpu (gnt_cpu)
   );

   assign owner[REQ_CPU] = gnt_cpu;
   assign owner[REQ_DMA] = dma_gnt;

   assign cpu_stall    = rst && cpu_req && !gnt_cpu;
   assign cpu_rdata    = (owner[REQ_CPU] && cpu_read) ? mem_rdata : '0;
   assign dma_read_gnt = owner[REQ_DMA] && !dma_we;

   // Memory port mux: the granted requester drives the port, an idle port is driven to zero
   always_comb begin
      mem_rd    = 1'b0;
      mem_wr    = 1'b0;
      mem_addr  = '0;
      mem_wdata = '0;
      if (owner[REQ_DMA]) begin
         mem_rd    = !dma_we;
         mem_wr    = dma_we;
         mem_addr  = dma_addr;
         mem_wdata = dma_wdata;
      end else if (owner[REQ_CPU]) begin
         mem_rd    = cpu_read;
         mem_wr    = cpu_wr;
         mem_addr  = cpu_addr;
         mem_wdata = cpu_wdata;
      end
   end

   // DMA read data is captured at the grant edge and held until the next granted read
   always_ff @(posedge clk) begin
      if (!rst) begin
         dma_rvalid <= 1'b0;
         dma_rdata  <= '0;
      end else begin
         dma_rvalid <= dma_read_gnt;
         if (dma_read_gnt) begin
            dma_rdata <= mem_rdata;
         end
      end
   end

`ifdef ARB_PERF_CNT_EN
   logic [31:0] stall_cnt;
   logic [31:0] dma_cnt;

   // Free-running wrapping counters of CPU stall cycles and DMA beats
   always_ff @(posedge clk) begin
      if (!rst) begin
         stall_cnt <= 32'd0;
         dma_cnt   <= 32'd0;
      end else begin
         if (cpu_stall) begin
            stall_cnt <= stall_cnt + 32'd1;
         end
         if (dma_gnt) begin
            dma_cnt <= dma_cnt + 32'd1;
         end
      end
   end

   assign perf_stall_cnt = stall_cnt;
   assign perf_dma_cnt   = dma_cnt;
`else
   assign perf_stall_cnt = 32'd0;
   assign perf_dma_cnt   = 32'd0;
`endif

endmodule

// File: doc/dmem_arbiter.md
Name: dmem_arbiter

Overview:
Shares the single data-memory port between the CPU MEM stage (requester 0) and an external DMA/loader master (requester 1, e.g. a UART program loader writing instruction/data images).
- The CPU has default priority. A starvation counter forces DMA slots.
- A lock FSM gives the DMA atomic bursts.
- The block sits between the EX/MEM pipeline register outputs and the data memory. Its cpu_stall feeds the pipeline hazard logic, which freezes PC, IF/ID, ID/EX and EX/MEM.

Parameters:
ADDR_W, 32, byte address width of both requesters and the memory port
DATA_W, 32, data width
STREAK_MAX, 4, consecutive CPU grants allowed while DMA waits before one DMA beat is forced (1..15)
BURST_MAX, 8, maximum beats in one locked DMA burst (1..255)

Ports:
clk  in  1  system clock
rst  in  1  synchronous active-low reset
cpu_rd  in  1  CPU MEM-stage read request
cpu_wr  in  1  CPU MEM-stage write request
cpu_addr  in  ADDR_W  CPU address
cpu_wdata  in  DATA_W  CPU write data (already forwarded)
cpu_rdata  out  DATA_W  read data, combinational, valid when cpu_rd && !cpu_stall
cpu_stall  out  1  CPU request not served this cycle; the pipeline must hold
dma_req  in  1  DMA request; held with addr/wdata/we until dma_gnt
dma_we  in  1  1 = write, 0 = read
dma_lock  in  1  request to keep ownership after this beat
dma_addr  in  ADDR_W  DMA address
dma_wdata  in  DATA_W  DMA write data
dma_gnt  out  1  beat accepted this cycle
dma_rdata  out  DATA_W  registered read data
dma_rvalid  out  1  dma_rdata valid (one cycle after a granted read)
mem_rd  out  1  memory read strobe
mem_wr  out  1  memory write strobe (memory writes on clk edge)
mem_addr  out  ADDR_W  memory address
mem_wdata  out  DATA_W  memory write data
mem_rdata  in  DATA_W  memory combinational read data
perf_stall_cnt  out  32  CPU stall cycle count (see Optional Feature)
perf_dma_cnt  out  32  DMA beat count (see Optional Feature)

Behaviour:
- Reset (rst==0 at a clk edge): state=S_CPU, streak=0, beats=0, dma_rdata=0, dma_rvalid=0, perf counters=0. In the reset cycle the combinational outputs are forced low: gnt, stall, mem_rd, mem_wr. A burst in progress is abandoned; the DMA must re-request.
- cpu_req = cpu_rd | cpu_wr. If cpu_rd and cpu_wr are both high, the write wins and no read occurs.
- S_CPU, grant decision each cycle (combinational):
  - dma_gnt = dma_req && (!cpu_req || streak==STREAK_MAX).
  - gnt_cpu = cpu_req && !dma_gnt.
- S_LOCK:
  - dma_gnt = dma_req.
  - gnt_cpu = 0.
  - cpu_stall = cpu_req.
- cpu_stall = cpu_req && !gnt_cpu, in all states.
- Memory mux:
  - On a DMA grant: DMA fields are driven; mem_wr=dma_we; mem_rd=!dma_we.
  - Else on a CPU grant: CPU fields are driven.
  - Else: mem_rd=mem_wr=0 and address/data are driven 0.
- streak counter:
  - +1 (saturating at STREAK_MAX) when gnt_cpu && dma_req.
  - Cleared on any dma_gnt, or on a cycle with !dma_req.
- Lock FSM:
  - S_CPU→S_LOCK when dma_gnt && dma_lock && BURST_MAX>1; beats is set to 1.
  - In S_LOCK, each dma_gnt increments beats.
  - S_LOCK→S_CPU on a granted beat with !dma_lock, or when beats+1==BURST_MAX, or on a cycle with !dma_req (abort, no beat). beats is cleared.
- dma_rvalid is registered: 1 for exactly one cycle after a granted DMA read; dma_rdata captures mem_rdata at that edge and holds until the next granted read.
- A DMA write granted in cycle N is visible to a CPU read in cycle N+1.
- Granted CPU accesses complete in the same cycle with zero added latency. A stalled CPU access completes in the first cycle gnt_cpu=1.

Optional Feature:
- Macro ARB_PERF_CNT_EN.
- Defined:
  - perf_stall_cnt increments every cycle cpu_stall=1.
  - perf_dma_cnt increments on every dma_gnt.
  - Both are 32-bit wrapping counters, cleared by reset.
- Undefined: both ports are tied to 0 and no counter flops are generated.

Decomposition:
- Shared package arb_pkg holds:
  - state encoding constants S_CPU=1'b0, S_LOCK=1'b1;
  - requester index constants REQ_CPU=0, REQ_DMA=1;
  - default STREAK_MAX and BURST_MAX values.
- One natural sub-module, arb_lock_fsm, holds state, beats and streak, and outputs the grant qualifiers. The top level holds the muxes, the read capture and the perf counters.

Test Plan:
1. Reset then CPU reads only: cpu_rd=1, addr 0x10, mem_rdata=0xDEADBEEF → cpu_rdata=0xDEADBEEF same cycle, cpu_stall=0, mem_rd=1, dma_rvalid=0.
2. DMA alone: dma_req=1, dma_we=0, addr 0x20 → dma_gnt same cycle; next cycle dma_rvalid=1 and dma_rdata=mem_rdata.
3. Starvation: cpu_rd held high for 10 cycles with dma_req high, STREAK_MAX=4 → CPU granted in cycles 0-3, DMA granted in cycle 4 with cpu_stall=1, CPU granted in cycles 5-8, DMA again in cycle 9.
4. Locked burst: dma_lock=1 for 10 beats, BURST_MAX=8, cpu_wr high → exactly 8 consecutive dma_gnt with cpu_stall=1; in cycle 9 the CPU write is granted with mem_wr=1 at the CPU address.
5. Abort and reset: dma_req drops mid-burst → S_CPU next cycle and a pending CPU request is granted. rst=0 mid-burst → all outputs 0 next cycle and dma_rvalid=0.
6. ARB_PERF_CNT_EN defined, scenario 3 run → perf_stall_cnt=2, perf_dma_cnt=2. Undefined → both read 0.
